// File: rtl/vt52_pkg.sv
// Shared constants for the VT52-style terminal: command opcodes, text geometry
// and the video-RAM writer state encoding.
package vt52_pkg;

    localparam logic [1:0] CMD_PUT    = 2'd0;
    localparam logic [1:0] CMD_SETPOS = 2'd1;
    localparam logic [1:0] CMD_CLEAR  = 2'd2;
    localparam logic [1:0] CMD_SCROLL = 2'd3;

    localparam int TEXT_START = 160;
    localparam int ROW_BYTES  = 80;
    localparam int ROWS_SHORT = 24;
    localparam int ROWS_LONG  = 38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLR,
        ST_SC_RD,
        ST_SC_WR,
        ST_SC_BLK
    } state_e;

endpackage

// File: rtl/vram_master_wb_single_access.sv
// One Wishbone access with a held strobe: cyc/stb rise after start_i and fall
// on the edge that samples ack; done_o pulses one cycle later with the read data.
module wb_single_access (
    input  logic        clk,
    input  logic        srst,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  sel_i,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    logic        cyc_q;
    logic        we_q;
    logic        done_q;
    logic [15:0] adr_q;
    logic [15:0] dat_q;
    logic [15:0] rdata_q;
    logic [1:0]  sel_q;

    // An ack seen while idle is ignored; start_i is only honoured while idle.
    always_ff @(posedge clk) begin
        if (srst) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (cyc_q) begin
                if (wb_ack_i) begin
                    cyc_q   <= 1'b0;
                    done_q  <= 1'b1;
                    rdata_q <= wb_dat_i;
                end
            end else if (start_i) begin
                cyc_q <= 1'b1;
                we_q  <= we_i;
                adr_q <= adr_i;
                dat_q <= dat_i;
                sel_q <= sel_i;
            end
        end
    end

    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;

endmodule

// File: rtl/vram_master.sv
// Wishbone initiator that writes terminal text into video RAM: character put,
// cursor set, clear screen and scroll-up, with auto-scroll past the last cell.
module vram_master
    import vt52_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE = 16'h0000,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_char,
    input  logic [5:0]  cmd_row,
    input  logic [6:0]  cmd_col,
    input  logic        lmode,
    output logic [12:0] cursor_o,
    output logic        busy,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i
);

    state_e      state_q;
    logic [12:0] cursor_q;
    logic [12:0] waddr_q;
    logic [12:0] text_end_q;
    logic [12:0] last_row_q;
    logic [7:0]  char_q;
    logic        start_q;

    logic [5:0]  nrows_d;
    logic [12:0] text_end_d;
    logic [12:0] pos_d;
    logic        pos_ok_d;
    logic [12:0] waddr_next;

    logic        acc_done;
    logic [15:0] acc_rdata;
    logic [12:0] acc_off;
    logic        acc_we;
    logic [15:0] acc_dat;
    logic [1:0]  acc_sel;

    assign nrows_d    = lmode ? 6'(ROWS_LONG) : 6'(ROWS_SHORT);
    assign text_end_d = lmode ? 13'(TEXT_START + ROWS_LONG * ROW_BYTES)
                              : 13'(TEXT_START + ROWS_SHORT * ROW_BYTES);
    // row*80 as row*64 + row*16
    assign pos_d      = 13'(TEXT_START) + {1'b0, cmd_row, 6'b0} + {3'b0, cmd_row, 4'b0}
                      + {6'b0, cmd_col};
    assign pos_ok_d   = (cmd_row < nrows_d) && (cmd_col < 7'(ROW_BYTES));
    assign waddr_next = waddr_q + 13'd2;

    // Access parameters follow the state that issues them; the bus stage latches them on start.
    always_comb begin
        acc_off = waddr_q;
        acc_we  = 1'b1;
        acc_dat = {BLANK, BLANK};
        acc_sel = 2'b11;
        case (state_q)
            ST_PUT: begin
                acc_off = {cursor_q[12:1], 1'b0};
                acc_dat = {char_q, char_q};
                acc_sel = cursor_q[0] ? 2'b10 : 2'b01;
            end
            ST_SC_RD: begin
                acc_off = waddr_q + 13'(ROW_BYTES);
                acc_we  = 1'b0;
            end
            ST_SC_WR: acc_dat = acc_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cursor_q   <= 13'(TEXT_START);
            waddr_q    <= '0;
            text_end_q <= '0;
            last_row_q <= '0;
            char_q     <= '0;
            start_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (cmd_valid) begin
                    text_end_q <= text_end_d;
                    last_row_q <= text_end_d - 13'(ROW_BYTES);
                    waddr_q    <= 13'(TEXT_START);
                    case (cmd_op)
                        CMD_PUT: begin
                            char_q  <= cmd_char;
                            start_q <= 1'b1;
                            state_q <= ST_PUT;
                        end
                        CMD_SETPOS: if (pos_ok_d) cursor_q <= pos_d;
                        CMD_CLEAR: begin
                            start_q <= 1'b1;
                            state_q <= ST_CLR;
                        end
                        CMD_SCROLL: begin
                            start_q <= 1'b1;
                            state_q <= ST_SC_RD;
                        end
                        default: ;
                    endcase
                end
                ST_PUT: if (acc_done) begin
                    if (cursor_q + 13'd1 == text_end_q) begin
                        cursor_q <= last_row_q;
                        waddr_q  <= 13'(TEXT_START);
                        start_q  <= 1'b1;
                        state_q  <= ST_SC_RD;
                    end else begin
                        cursor_q <= cursor_q + 13'd1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_CLR: if (acc_done) begin
                    if (waddr_next == text_end_q) begin
                        cursor_q <= 13'(TEXT_START);
                        state_q  <= ST_IDLE;
                    end else begin
                        waddr_q <= waddr_next;
                        start_q <= 1'b1;
                    end
                end
                ST_SC_RD: if (acc_done) begin
                    start_q <= 1'b1;
                    state_q <= ST_SC_WR;
                end
                ST_SC_WR: if (acc_done) begin
                    waddr_q <= waddr_next;
                    start_q <= 1'b1;
                    state_q <= (waddr_next == last_row_q) ? ST_SC_BLK : ST_SC_RD;
                end
                ST_SC_BLK: if (acc_done) begin
                    if (waddr_next == text_end_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        waddr_q <= waddr_next;
                        start_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wb_single_access u_access (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .start_i  (start_q),
        .we_i     (acc_we),
        .adr_i    (VRAM_BASE + 16'(acc_off)),
        .dat_i    (acc_dat),
        .sel_i    (acc_sel),
        .done_o   (acc_done),
        .rdata_o  (acc_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign cursor_o  = cursor_q;

endmodule

// File: tb/tb_vram_master.sv
// Bench for vram_master: a Wishbone memory responder with random wait states
// and a byte-level text-screen model that predicts cursor, access counts and VRAM.
module tb_vram_master;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_char;
    logic [5:0]  cmd_row;
    logic [6:0]  cmd_col;
    logic        lmode;
    logic [12:0] cursor;
    logic        busy;
    logic [15:0] wb_adr;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic        wb_ack;

    vram_master dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_char  (cmd_char),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .lmode     (lmode),
        .cursor_o  (cursor),
        .busy      (busy),
        .wb_adr_o  (wb_adr),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_cyc_o  (wb_cyc),
        .wb_stb_o  (wb_stb),
        .wb_we_o   (wb_we),
        .wb_sel_o  (wb_sel),
        .wb_ack_i  (wb_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int ack_cycle = -1;
    int done_cycle = 0;
    int cyc_hold_bad = 0;
    int ack_delay = 0;
    bit rand_delay = 1'b0;
    int max_rand_delay = 3;

    logic [7:0] bmem [0:8191];
    logic [7:0] emem [0:8191];
    int         ecur;
    int         exp_n;
    acc_t       log_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic acc_t get_acc(input int i);
        acc_t a;
        a = '{we: 1'bx, adr: 16'hxxxx, sel: 2'bxx, dat: 16'hxxxx};
        if (i >= 0 && i < log_q.size()) a = log_q[i];
        return a;
    endfunction

    // Memory responder: acks after a chosen number of wait cycles, logs each access.
    initial begin : responder
        acc_t pend;
        int   wait_cnt;
        int   cur_delay;
        bit   fresh;
        int   a;
        wb_ack   = 1'b0;
        wb_dat_i = '0;
        wait_cnt = 0;
        cur_delay = 0;
        fresh    = 1'b1;
        pend     = '{we: 1'b0, adr: 16'h0, sel: 2'b0, dat: 16'h0};
        forever begin
            @(negedge clk);
            if (wb_ack) begin
                wb_ack = 1'b0;
                if (!rst) begin
                    ack_cycle = cyc_cnt;
                    if (wb_cyc) cyc_hold_bad++;
                    log_q.push_back(pend);
                    a = {19'd0, pend.adr[12:1], 1'b0};
                    if (pend.we && pend.sel[0]) bmem[a]     = pend.dat[7:0];
                    if (pend.we && pend.sel[1]) bmem[a + 1] = pend.dat[15:8];
                end
                wait_cnt = 0;
                fresh    = 1'b1;
            end else if (rst) begin
                wait_cnt = 0;
                fresh    = 1'b1;
            end else if (wb_cyc && wb_stb) begin
                if (fresh) begin
                    cur_delay = rand_delay ? $urandom_range(0, max_rand_delay) : ack_delay;
                    fresh = 1'b0;
                end
                if (wait_cnt >= cur_delay) begin
                    pend = '{we: wb_we, adr: wb_adr, sel: wb_sel, dat: wb_dat_o};
                    a = {19'd0, wb_adr[12:1], 1'b0};
                    wb_dat_i = {bmem[a + 1], bmem[a]};
                    wb_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Screen-level reference: rows shift up by one, bottom row blanks.
    task automatic model_scroll(input int nrows);
        int lr = 160 + (nrows - 1) * 80;
        for (int b = 160; b < lr; b++) emem[b] = emem[b + 80];
        for (int b = lr; b < lr + 80; b++) emem[b] = 8'h20;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] ch,
                               input int row, input int col, input logic lm);
        int nrows = lm ? 38 : 24;
        int te    = 160 + nrows * 80;
        exp_n = 0;
        case (op)
            2'd0: begin
                emem[ecur] = ch;
                exp_n = 1;
                ecur++;
                if (ecur == te) begin
                    ecur = te - 80;
                    model_scroll(nrows);
                    exp_n += (nrows - 1) * 80 + 40;
                end
            end
            2'd1: if (row < nrows && col < 80) ecur = 160 + row * 80 + col;
            2'd2: begin
                for (int b = 160; b < te; b++) emem[b] = 8'h20;
                ecur  = 160;
                exp_n = nrows * 40;
            end
            default: begin
                model_scroll(nrows);
                exp_n = (nrows - 1) * 80 + 40;
            end
        endcase
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] ch, input int row,
                          input int col, input logic lm, input string tag);
        int t;
        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        cmd_row   = 6'(row);
        cmd_col   = 7'(col);
        lmode     = lm;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 30000) begin
            @(negedge clk);
            t++;
        end
        done_cycle = cyc_cnt;
        check({tag, "_done"}, {31'd0, cmd_ready}, 32'd1);
        model_apply(op, ch, row, col, lm);
        check({tag, "_cursor"}, {19'd0, cursor}, ecur);
        check({tag, "_nacc"}, log_q.size(), exp_n);
        $display("[TB] %s op=%0d char=%0h row=%0d col=%0d lmode=%0d accesses=%0d cursor=%0d",
                 tag, op, ch, row, col, lm, log_q.size(), cursor);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 8192; i++) if (bmem[i] !== emem[i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    task automatic check_scroll_seq(input int first, input int nrows, input string tag);
        int   bad = 0;
        int   pairs = (nrows - 1) * 40;
        int   lr = 160 + (nrows - 1) * 80;
        acc_t r;
        acc_t w;
        for (int i = 0; i < pairs; i++) begin
            r = get_acc(first + 2 * i);
            w = get_acc(first + 2 * i + 1);
            if (r.we !== 1'b0 || r.adr !== 16'(240 + 2 * i)) bad++;
            if (w.we !== 1'b1 || w.adr !== 16'(160 + 2 * i) || w.sel !== 2'b11) bad++;
        end
        for (int j = 0; j < 40; j++) begin
            w = get_acc(first + 2 * pairs + j);
            if (w.we !== 1'b1 || w.adr !== 16'(lr + 2 * j) || w.sel !== 2'b11 ||
                w.dat !== 16'h2020) bad++;
        end
        check({tag, "_seq"}, bad, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        acc_t       a;
        logic [7:0] old_row1 [0:79];
        int         bad;
        int         big;
        int         r;
        int         t;
        logic       lm;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_char = '0;
        cmd_row = '0;
        cmd_col = '0;
        lmode = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            bmem[i] = 8'($urandom);
            emem[i] = bmem[i];
        end
        ecur = 160;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", {31'd0, wb_cyc}, 0);
        check("rst_stb", {31'd0, wb_stb}, 0);
        check("rst_we", {31'd0, wb_we}, 0);
        check("rst_sel", {30'd0, wb_sel}, 0);
        check("rst_adr", {16'd0, wb_adr}, 0);
        check("rst_dat", {16'd0, wb_dat_o}, 0);
        check("rst_cursor", {19'd0, cursor}, 160);
        check("rst_ready", {31'd0, cmd_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;

        // First PUT with a fixed two-cycle wait
        ack_delay = 2;
        do_cmd(2'd0, 8'h41, 0, 0, 1'b0, "put1");
        a = get_acc(0);
        check("put1_adr", {16'd0, a.adr}, 160);
        check("put1_sel", {30'd0, a.sel}, 1);
        check("put1_dat", {16'd0, a.dat}, 32'h4141);
        check("put1_we", {31'd0, a.we}, 1);
        check("put1_ready_lat", done_cycle - ack_cycle, 1);

        do_cmd(2'd0, 8'h42, 0, 0, 1'b0, "put2");
        a = get_acc(0);
        check("put2_adr", {16'd0, a.adr}, 160);
        check("put2_sel", {30'd0, a.sel}, 2);
        check("put2_dat", {16'd0, a.dat}, 32'h4242);
        check("put2_cyc_drop", cyc_hold_bad, 0);

        do_cmd(2'd1, 8'h00, 5, 10, 1'b0, "setpos_5_10");
        check("setpos_570", {19'd0, cursor}, 570);
        do_cmd(2'd1, 8'h00, 24, 0, 1'b0, "setpos_bad");
        do_cmd(2'd1, 8'h00, 24, 0, 1'b1, "setpos_long");
        check("setpos_2080", {19'd0, cursor}, 2080);

        ack_delay = 0;
        do_cmd(2'd2, 8'h00, 0, 0, 1'b0, "clear");
        bad = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            a = log_q[i];
            if (a.we !== 1'b1 || a.dat !== 16'h2020 || a.sel !== 2'b11 ||
                a.adr !== 16'(160 + 2 * i)) bad++;
        end
        check("clear_seq", bad, 0);
        a = get_acc(959);
        check("clear_last_adr", {16'd0, a.adr}, 2078);
        check_mem("clear");

        // Auto-scroll from the last cell of a fresh random screen
        for (int i = 0; i < 8192; i++) begin
            bmem[i] = 8'($urandom);
            emem[i] = bmem[i];
        end
        for (int k = 0; k < 80; k++) old_row1[k] = bmem[240 + k];
        rand_delay = 1'b1;
        max_rand_delay = 2;
        do_cmd(2'd1, 8'h00, 23, 79, 1'b0, "setpos_23_79");
        check("setpos_2079", {19'd0, cursor}, 2079);
        do_cmd(2'd0, 8'h5A, 0, 0, 1'b0, "autoscroll");
        a = get_acc(0);
        check("as_put_adr", {16'd0, a.adr}, 2078);
        check("as_put_sel", {30'd0, a.sel}, 2);
        a = get_acc(1);
        check("as_first_rd", {15'd0, a.we, a.adr}, 240);
        a = get_acc(2);
        check("as_first_wr", {15'd0, a.we, a.adr}, 32'h10000 + 160);
        check_scroll_seq(1, 24, "as");
        check("as_cursor_2000", {19'd0, cursor}, 2000);
        bad = 0;
        for (int k = 0; k < 80; k++) if (bmem[160 + k] !== old_row1[k]) bad++;
        check("as_row0_old_row1", bad, 0);
        check_mem("autoscroll");

        // Randomised command mix against the screen model
        max_rand_delay = 1;
        big = 0;
        for (int k = 0; k < 50; k++) begin
            r  = $urandom_range(0, 99);
            lm = 1'($urandom_range(0, 1));
            if (r < 55 || (r >= 85 && big >= 3)) begin
                do_cmd(2'd0, 8'($urandom), 0, 0, lm, $sformatf("rnd%0d_put", k));
            end else if (r < 85) begin
                do_cmd(2'd1, 8'h00, $urandom_range(0, 40), $urandom_range(0, 90), lm,
                       $sformatf("rnd%0d_setpos", k));
            end else if (r < 90) begin
                big++;
                do_cmd(2'd1, 8'h00, lm ? 37 : 23, 79, lm, $sformatf("rnd%0d_setend", k));
                do_cmd(2'd0, 8'($urandom), 0, 0, lm, $sformatf("rnd%0d_putend", k));
            end else if (r < 95) begin
                big++;
                do_cmd(2'd2, 8'h00, 0, 0, lm, $sformatf("rnd%0d_clear", k));
            end else begin
                big++;
                do_cmd(2'd3, 8'h00, 0, 0, lm, $sformatf("rnd%0d_scroll", k));
                check_scroll_seq(0, lm ? 38 : 24, $sformatf("rnd%0d_scroll", k));
            end
        end
        check_mem("random");

        // Reset in the middle of a scroll
        rand_delay = 1'b0;
        ack_delay  = 0;
        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        lmode     = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        t = 0;
        while (log_q.size() < 200 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_reached", {31'd0, log_q.size() >= 200}, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_mid_cyc", {31'd0, wb_cyc}, 0);
        check("rst_mid_stb", {31'd0, wb_stb}, 0);
        check("rst_mid_cursor", {19'd0, cursor}, 160);
        check("rst_mid_ready", {31'd0, cmd_ready}, 1);
        $display("[TB] reset during scroll after %0d accesses cursor=%0d", log_q.size(), cursor);
        rst = 1'b0;
        for (int i = 0; i < 8192; i++) emem[i] = bmem[i];
        ecur = 160;
        do_cmd(2'd0, 8'h55, 0, 0, 1'b0, "put_after_rst");
        a = get_acc(0);
        check("put_after_rst_adr", {16'd0, a.adr}, 160);
        check("put_after_rst_sel", {30'd0, a.sel}, 1);
        check_mem("final");
        check("cyc_drop_on_ack", cyc_hold_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
